// File: rtl/wta_pkg.sv
// Shared constants and arithmetic helpers for the winner-take-all LIF array.
package wta_pkg;

    // Default configuration of the array
    localparam int N_NEURONS_DEF     = 4;
    localparam int CUR_W_DEF         = 8;
    localparam int STATE_W_DEF       = 8;
    localparam int THRESHOLD_DEF     = 200;
    localparam int LEAK_SHIFT_DEF    = 2;
    localparam int REFRAC_CYCLES_DEF = 3;
    localparam int INHIB_DEF         = 32;

    // Working width of the helper functions; callers cast in and out
    localparam int ARITH_W = 32;

    // Unsigned add clamped to max_val; the extra carry bit rules out wrap-around
    function automatic logic [ARITH_W-1:0] sat_add(input logic [ARITH_W-1:0] a,
                                                   input logic [ARITH_W-1:0] b,
                                                   input logic [ARITH_W-1:0] max_val);
        logic [ARITH_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[ARITH_W-1:0];
    endfunction

    // Unsigned subtract clamped at zero
    function automatic logic [ARITH_W-1:0] sat_sub(input logic [ARITH_W-1:0] a,
                                                   input logic [ARITH_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

    // Width of a neuron index
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lif_neuron_core.sv
// One leaky integrate-and-fire neuron: membrane state, refractory counter,
// leak/integrate/saturate candidate and fire eligibility.
module lif_neuron_core import wta_pkg::*; #(
    parameter int CUR_W         = CUR_W_DEF,
    parameter int STATE_W       = STATE_W_DEF,
    parameter int THRESHOLD     = THRESHOLD_DEF,
    parameter int LEAK_SHIFT    = LEAK_SHIFT_DEF,
    parameter int REFRAC_CYCLES = REFRAC_CYCLES_DEF,
    parameter int INHIB         = INHIB_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [CUR_W-1:0]   current,
    input  logic               fire,
    input  logic               inhibit_hard,
    input  logic               inhibit_soft,
    output logic [STATE_W-1:0] cand,
    output logic               eligible,
    output logic [STATE_W-1:0] state
);

    localparam int                 RC_W      = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;
    localparam logic [RC_W-1:0]    RC_LOAD   = RC_W'(REFRAC_CYCLES);
    localparam logic [ARITH_W-1:0] STATE_MAX = ARITH_W'((64'd1 << STATE_W) - 64'd1);

    logic [STATE_W-1:0] state_p1;
    logic [RC_W-1:0]    refrac_p1;
    logic               busy_p0;
    logic [STATE_W-1:0] leaked_p0;
    logic [STATE_W-1:0] soft_p0;

    // Stage p0: leak, integrate and saturate the current state into a candidate
    always_comb begin
        busy_p0   = (refrac_p1 != '0);
        leaked_p0 = state_p1 - (state_p1 >> LEAK_SHIFT);
        cand      = '0;
        if (!busy_p0) begin
            cand = STATE_W'(sat_add(ARITH_W'(leaked_p0), ARITH_W'(current), STATE_MAX));
        end
        eligible  = !busy_p0 && (ARITH_W'(cand) >= ARITH_W'(THRESHOLD));
        soft_p0   = STATE_W'(sat_sub(ARITH_W'(cand), ARITH_W'(INHIB)));
    end

    // Stage p1: commit the candidate, apply winner/loser handling, run refractory count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1  <= '0;
            refrac_p1 <= '0;
        end else if (en) begin
            if (busy_p0) begin
                refrac_p1 <= refrac_p1 - RC_W'(1);
                state_p1  <= '0;
            end else if (fire) begin
                state_p1  <= '0;
                refrac_p1 <= RC_LOAD;
            end else if (inhibit_hard) begin
                state_p1  <= '0;
            end else if (inhibit_soft) begin
                state_p1  <= soft_p0;
            end else begin
                state_p1  <= cand;
            end
        end
    end

    assign state = state_p1;

endmodule

// File: rtl/wta_lif_array.sv
// Winner-take-all array of LIF neurons: picks the strongest eligible neuron
// (lowest index on ties), fires it and suppresses the rest hard or soft.
module wta_lif_array import wta_pkg::*; #(
    parameter int N_NEURONS     = N_NEURONS_DEF,
    parameter int CUR_W         = CUR_W_DEF,
    parameter int STATE_W       = STATE_W_DEF,
    parameter int THRESHOLD     = THRESHOLD_DEF,
    parameter int LEAK_SHIFT    = LEAK_SHIFT_DEF,
    parameter int REFRAC_CYCLES = REFRAC_CYCLES_DEF,
    parameter int INHIB         = INHIB_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            mode,
    input  logic [N_NEURONS*CUR_W-1:0]      current,
    input  logic [idx_w(N_NEURONS)-1:0]     sel,
    output logic [N_NEURONS-1:0]            spike,
    output logic [idx_w(N_NEURONS)-1:0]     winner_idx,
    output logic                            winner_valid,
    output logic [STATE_W-1:0]              state_out
);

    localparam int IDX_W = idx_w(N_NEURONS);

    logic [STATE_W-1:0] cand_p0  [N_NEURONS];
    logic [STATE_W-1:0] state_p1 [N_NEURONS];
    logic [N_NEURONS-1:0] elig_p0;
    logic [N_NEURONS-1:0] fire_p0;
    logic                 win_any_p0;
    logic [STATE_W-1:0]   win_val_p0;
    logic [IDX_W-1:0]     win_idx_p0;
    logic                 inhibit_hard_p0;
    logic                 inhibit_soft_p0;

    for (genvar i = 0; i < N_NEURONS; i++) begin : g_neuron
        lif_neuron_core #(
            .CUR_W         (CUR_W),
            .STATE_W       (STATE_W),
            .THRESHOLD     (THRESHOLD),
            .LEAK_SHIFT    (LEAK_SHIFT),
            .REFRAC_CYCLES (REFRAC_CYCLES),
            .INHIB         (INHIB)
        ) u_core (
            .clk          (clk),
            .rst_n        (rst_n),
            .en           (en),
            .current      (current[i*CUR_W +: CUR_W]),
            .fire         (fire_p0[i]),
            .inhibit_hard (inhibit_hard_p0),
            .inhibit_soft (inhibit_soft_p0),
            .cand         (cand_p0[i]),
            .eligible     (elig_p0[i]),
            .state        (state_p1[i])
        );
    end

    // Stage p0: argmax over eligible candidates; strict '>' keeps the lowest index on ties
    always_comb begin
        win_any_p0 = 1'b0;
        win_val_p0 = '0;
        win_idx_p0 = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (elig_p0[i] && (!win_any_p0 || (cand_p0[i] > win_val_p0))) begin
                win_any_p0 = 1'b1;
                win_val_p0 = cand_p0[i];
                win_idx_p0 = IDX_W'(i);
            end
        end
    end

    // Stage p0: one-hot fire strobe and loser suppression for the neuron cores
    always_comb begin
        fire_p0 = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            fire_p0[i] = win_any_p0 && (win_idx_p0 == IDX_W'(i));
        end
        inhibit_hard_p0 = win_any_p0 && !mode;
        inhibit_soft_p0 = win_any_p0 && mode;
    end

    // Stage p1: registered spike vector, winner pulse and sticky winner index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike        <= '0;
            winner_valid <= 1'b0;
            winner_idx   <= '0;
        end else if (en) begin
            spike        <= fire_p0;
            winner_valid <= win_any_p0;
            if (win_any_p0) begin
                winner_idx <= win_idx_p0;
            end
        end else begin
            spike        <= '0;
            winner_valid <= 1'b0;
        end
    end

    // Observation mux of the selected neuron's membrane state
    always_comb begin
        state_out = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (sel == IDX_W'(i)) begin
                state_out = state_p1[i];
            end
        end
    end

endmodule

// File: tb/tb_wta_lif_array.sv
// Directed and randomised bench for wta_lif_array (default build plus a
// THRESHOLD=255 build sharing the same stimulus).
module tb_wta_lif_array;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic [31:0] current;
    logic [1:0]  sel;

    logic [3:0]  spike,        spike_s;
    logic [1:0]  winner_idx,   winner_idx_s;
    logic        winner_valid, winner_valid_s;
    logic [7:0]  state_out,    state_out_s;

    int checks = 0;
    int errors = 0;

    // Reference model of the default build
    int ms[4];
    int mr[4];
    int m_widx;

    always #5 clk = ~clk;

    wta_lif_array dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .mode         (mode),
        .current      (current),
        .sel          (sel),
        .spike        (spike),
        .winner_idx   (winner_idx),
        .winner_valid (winner_valid),
        .state_out    (state_out)
    );

    wta_lif_array #(.THRESHOLD(255)) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .mode         (mode),
        .current      (current),
        .sel          (sel),
        .spike        (spike_s),
        .winner_idx   (winner_idx_s),
        .winner_valid (winner_valid_s),
        .state_out    (state_out_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cur(input int c0, input int c1, input int c2, input int c3);
        current = {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    endtask

    task automatic peek(input string tag, input bit use_sat, input int idx, input int exp);
        sel = 2'(idx);
        #1;
        check(tag, use_sat ? 32'(state_out_s) : 32'(state_out), 32'(exp));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 1'b0;
        sel   = 2'd0;
        set_cur(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ms[i] = 0;
            mr[i] = 0;
        end
        m_widx = 0;
    endtask

    task automatic model_step(input bit e, input bit md, input logic [31:0] cur,
                              output logic [3:0] exp_spike, output logic [3:0] busy);
        int cand[4];
        int win;
        int best;
        busy = '0;
        for (int i = 0; i < 4; i++) busy[i] = (mr[i] > 0);
        exp_spike = '0;
        if (!e) return;
        for (int i = 0; i < 4; i++) begin
            if (mr[i] > 0) cand[i] = 0;
            else begin
                cand[i] = ms[i] - (ms[i] >> 2) + int'(cur[i*8 +: 8]);
                if (cand[i] > 255) cand[i] = 255;
            end
        end
        win  = -1;
        best = -1;
        for (int i = 0; i < 4; i++) begin
            if (mr[i] == 0 && cand[i] >= 200 && cand[i] > best) begin
                best = cand[i];
                win  = i;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (mr[i] > 0) begin
                mr[i]--;
                ms[i] = 0;
            end else if (i == win) begin
                ms[i] = 0;
                mr[i] = 3;
            end else if (win >= 0) begin
                ms[i] = md ? ((cand[i] > 32) ? cand[i] - 32 : 0) : 0;
            end else begin
                ms[i] = cand[i];
            end
        end
        if (win >= 0) begin
            exp_spike[win] = 1'b1;
            m_widx = win;
        end
    endtask

    initial begin
        logic [3:0] exp_spike;
        logic [3:0] busy;

        // Reset state
        do_reset();
        check("rst_spike", 32'(spike), 0);
        check("rst_valid", 32'(winner_valid), 0);
        check("rst_idx", 32'(winner_idx), 0);
        for (int i = 0; i < 4; i++) peek("rst_state", 0, i, 0);

        // Single drive, hard mode
        en = 1'b1;
        set_cur(100, 0, 0, 0);
        sel = 2'd0;
        step(); peek("single_e1", 0, 0, 100); check("single_e1_spike", 32'(spike), 0);
        step(); peek("single_e2", 0, 0, 175); check("single_e2_spike", 32'(spike), 0);
        step();
        check("single_fire_spike", 32'(spike), 32'b0001);
        check("single_fire_valid", 32'(winner_valid), 1);
        check("single_fire_idx", 32'(winner_idx), 0);
        peek("single_fire_state", 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            peek("single_refrac_state", 0, 0, 0);
            check("single_refrac_spike", 32'(spike), 0);
            check("single_refrac_valid", 32'(winner_valid), 0);
        end
        step(); peek("single_resume", 0, 0, 100);

        // Tie between neuron 0 and 2
        do_reset();
        en = 1'b1;
        set_cur(250, 0, 250, 0);
        step();
        check("tie_spike", 32'(spike), 32'b0001);
        check("tie_idx", 32'(winner_idx), 0);
        peek("tie_state0", 0, 0, 0);
        peek("tie_state1", 0, 1, 0);
        peek("tie_state2", 0, 2, 0);
        peek("tie_state3", 0, 3, 0);

        // Soft inhibition
        do_reset();
        en   = 1'b1;
        mode = 1'b1;
        set_cur(250, 150, 0, 0);
        step();
        check("soft_e1_spike", 32'(spike), 32'b0001);
        peek("soft_e1_state1", 0, 1, 118);
        step();
        check("soft_e2_spike", 32'(spike), 32'b0010);
        check("soft_e2_idx", 32'(winner_idx), 1);
        check("soft_e2_valid", 32'(winner_valid), 1);

        // Asynchronous reset while neuron 0 is refractory
        rst_n = 1'b0;
        #1;
        check("async_rst_spike", 32'(spike), 0);
        check("async_rst_valid", 32'(winner_valid), 0);
        check("async_rst_idx", 32'(winner_idx), 0);
        peek("async_rst_state1", 0, 1, 0);
        rst_n = 1'b1;
        mode  = 1'b0;
        set_cur(100, 0, 0, 0);
        step();
        peek("post_rst_state0", 0, 0, 100);
        check("post_rst_spike", 32'(spike), 0);

        // Saturation and enable hold on the THRESHOLD=255 build
        do_reset();
        en   = 1'b1;
        mode = 1'b1;
        set_cur(100, 200, 0, 0);
        step();
        check("sat_e1_spike", 32'(spike_s), 0);
        peek("sat_e1_state1", 1, 1, 200);
        step();
        check("sat_e2_spike", 32'(spike_s), 32'b0010);
        check("sat_e2_idx", 32'(winner_idx_s), 1);
        peek("sat_e2_state0", 1, 0, 143);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("hold_spike", 32'(spike_s), 0);
            check("hold_valid", 32'(winner_valid_s), 0);
            check("hold_idx", 32'(winner_idx_s), 1);
            peek("hold_state0", 1, 0, 143);
            peek("hold_state1", 1, 1, 0);
        end
        en = 1'b1;
        step();
        peek("sat_e3_state0", 1, 0, 208);
        peek("sat_e3_state1", 1, 1, 0);
        check("sat_e3_spike", 32'(spike_s), 0);
        step();
        check("sat_e4_spike", 32'(spike_s), 32'b0001);
        check("sat_e4_idx", 32'(winner_idx_s), 0);
        peek("sat_e4_state1", 1, 1, 0);
        step();
        peek("sat_e5_state1", 1, 1, 0);
        step();
        peek("sat_e6_state1", 1, 1, 200);

        // Randomised run against the reference model
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            en   = ($urandom_range(0, 9) != 0);
            mode = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                current[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                                 : 8'($urandom_range(0, 120));
            end
            sel = 2'($urandom_range(0, 3));
            model_step(en, mode, current, exp_spike, busy);
            step();
            check("rand_spike", 32'(spike), 32'(exp_spike));
            check("rand_valid", 32'(winner_valid), 32'(|spike));
            check("rand_refrac_spike", 32'(spike & busy), 0);
            check("rand_idx", 32'(winner_idx), 32'(m_widx));
            check("rand_state", 32'(state_out), 32'(ms[sel]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
